// File: rtl/lc3b_types.sv
// Shared LC-3b types for the load/store execution stage.
// Opcode encoding, word/tag types and the ld/str FSM state enum.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_rob_addr;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        MEM1,
        INDIR,
        MEM2,
        BCAST
    } ldst_state_t;

    // Word ops scale the offset by 2 and need an even address.
    function automatic logic is_word_op(lc3b_opcode op);
        return (op == op_ldr) || (op == op_str) ||
               (op == op_ldi) || (op == op_sti);
    endfunction

    // Indirect ops fetch a pointer before the real access.
    function automatic logic is_indirect(lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

    // Ops whose first access is a write.
    function automatic logic is_direct_store(lc3b_opcode op);
        return (op == op_str) || (op == op_stb);
    endfunction

endpackage

// File: rtl/ldst_addr_gen.sv
// Combinational address, byte-lane and byte-extract logic
// for the load/store execution stage.
module ldst_addr_gen
    import lc3b_types::*;
#(
    parameter int data_width = 16
) (
    input  lc3b_opcode            opcode,
    input  logic [data_width-1:0] vbase,
    input  logic [data_width-1:0] offset,
    input  logic [data_width-1:0] addr,
    input  logic [data_width-1:0] vsrc,
    input  logic [data_width-1:0] rdata,
    output logic [data_width-1:0] ea,
    output logic [data_width-1:0] mem_address,
    output logic [data_width-1:0] wdata,
    output logic [1:0]            byte_enable,
    output logic [data_width-1:0] load_value
);

    logic [7:0] byte_sel;

    // Effective address: word ops scale the raw offset by two.
    always_comb begin
        if (is_word_op(opcode))
            ea = vbase + (offset << 1);
        else
            ea = vbase + offset;
    end

    assign mem_address = {addr[data_width-1:1], 1'b0};

    // Store lanes: STB replicates the byte and picks one lane.
    always_comb begin
        wdata       = vsrc;
        byte_enable = 2'b11;
        if (opcode == op_stb) begin
            wdata       = '0;
            wdata[15:0] = {vsrc[7:0], vsrc[7:0]};
            byte_enable = addr[0] ? 2'b10 : 2'b01;
        end
    end

    // Load result: LDB sign-extends the addressed byte.
    always_comb begin
        byte_sel   = addr[0] ? rdata[15:8] : rdata[7:0];
        load_value = rdata;
        if (opcode == op_ldb)
            load_value = {{(data_width-8){byte_sel[7]}}, byte_sel};
    end

endmodule

// File: rtl/ld_str_exec_unit.sv
// Non-pipelined load/store execution stage: EA, memory access(es), CDB.
// Optional LDST_ALIGN_CHECK_EN adds cdb_exc for misaligned word accesses.
module ld_str_exec_unit
    import lc3b_types::*;
#(
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  lc3b_opcode            opcode_in,
    input  logic [data_width-1:0] Vbase_in,
    input  logic [data_width-1:0] offset_in,
    input  logic [data_width-1:0] Vsrc_in,
    input  logic [tag_width-1:0]  dest_in,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [data_width-1:0] mem_address,
    output logic [data_width-1:0] mem_wdata,
    output logic [1:0]            mem_byte_enable,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  cdb_valid,
    output logic [tag_width-1:0]  cdb_tag,
    output logic [data_width-1:0] cdb_value,
    input  logic                  cdb_ack
`ifdef LDST_ALIGN_CHECK_EN
    ,
    output logic                  cdb_exc
`endif
);

    ldst_state_t state, state_next;

    lc3b_opcode            op_q;
    logic [data_width-1:0] vbase_q;
    logic [data_width-1:0] offset_q;
    logic [data_width-1:0] vsrc_q;
    logic [tag_width-1:0]  dest_q;
    logic [data_width-1:0] addr_q;
    logic [data_width-1:0] result_q;

    logic [data_width-1:0] ag_ea;
    logic [data_width-1:0] ag_address;
    logic [data_width-1:0] ag_wdata;
    logic [1:0]            ag_be;
    logic [data_width-1:0] ag_load;

    logic ea_bad;
    logic ptr_bad;

    ldst_addr_gen #(
        .data_width(data_width)
    ) u_addr_gen (
        .opcode     (op_q),
        .vbase      (vbase_q),
        .offset     (offset_q),
        .addr       (addr_q),
        .vsrc       (vsrc_q),
        .rdata      (mem_rdata),
        .ea         (ag_ea),
        .mem_address(ag_address),
        .wdata      (ag_wdata),
        .byte_enable(ag_be),
        .load_value (ag_load)
    );

`ifdef LDST_ALIGN_CHECK_EN
    logic exc_q;
    assign ea_bad  = is_word_op(op_q) && ag_ea[0];
    assign ptr_bad = addr_q[0];
    assign cdb_exc = exc_q;
`else
    assign ea_bad  = 1'b0;
    assign ptr_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (flush)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        cdb_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = ADDR;
            end
            ADDR: begin
                state_next = ea_bad ? BCAST : MEM1;
            end
            MEM1: begin
                mem_read  = !is_direct_store(op_q);
                mem_write = is_direct_store(op_q);
                if (mem_resp)
                    state_next = is_indirect(op_q) ? INDIR : BCAST;
            end
            INDIR: begin
                state_next = ptr_bad ? BCAST : MEM2;
            end
            MEM2: begin
                mem_read  = (op_q == op_ldi);
                mem_write = (op_q == op_sti);
                if (mem_resp)
                    state_next = BCAST;
            end
            BCAST: begin
                cdb_valid = 1'b1;
                if (cdb_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side data outputs are quiet outside an access.
    always_comb begin
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = 2'b00;
        if (mem_read || mem_write)
            mem_address = ag_address;
        if (mem_write) begin
            mem_wdata       = ag_wdata;
            mem_byte_enable = ag_be;
        end
    end

    assign cdb_tag   = dest_q;
    assign cdb_value = result_q;

    // Operand latches, address and result capture.
    always_ff @(posedge clk) begin
        if (flush) begin
            op_q     <= op_br;
            vbase_q  <= '0;
            offset_q <= '0;
            vsrc_q   <= '0;
            dest_q   <= '0;
            addr_q   <= '0;
            result_q <= '0;
`ifdef LDST_ALIGN_CHECK_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= opcode_in;
                        vbase_q  <= Vbase_in;
                        offset_q <= offset_in;
                        vsrc_q   <= Vsrc_in;
                        dest_q   <= dest_in;
                        result_q <= '0;
`ifdef LDST_ALIGN_CHECK_EN
                        exc_q    <= 1'b0;
`endif
                    end
                end
                ADDR: begin
                    addr_q <= ag_ea;
`ifdef LDST_ALIGN_CHECK_EN
                    if (ea_bad)
                        exc_q <= 1'b1;
`endif
                end
                MEM1: begin
                    if (mem_resp) begin
                        if (is_indirect(op_q))
                            addr_q <= mem_rdata;
                        else if (!is_direct_store(op_q))
                            result_q <= ag_load;
                    end
                end
                INDIR: begin
`ifdef LDST_ALIGN_CHECK_EN
                    if (ptr_bad)
                        exc_q <= 1'b1;
`endif
                end
                MEM2: begin
                    if (mem_resp && op_q == op_ldi)
                        result_q <= ag_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ld_str_exec_unit.sv
// Self-checking bench for ld_str_exec_unit: directed cases then
// random ops against an access-plan reference model.
module tb_ld_str_exec_unit;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        flush = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    lc3b_opcode  opcode_in = op_br;
    logic [15:0] Vbase_in = '0;
    logic [15:0] offset_in = '0;
    logic [15:0] Vsrc_in = '0;
    logic [2:0]  dest_in = '0;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic        cdb_ack = 1'b0;
`ifdef LDST_ALIGN_CHECK_EN
    logic        cdb_exc;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ld_str_exec_unit #(
        .data_width(16),
        .tag_width (3)
    ) dut (
        .clk            (clk),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .opcode_in      (opcode_in),
        .Vbase_in       (Vbase_in),
        .offset_in      (offset_in),
        .Vsrc_in        (Vsrc_in),
        .dest_in        (dest_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_ack        (cdb_ack)
`ifdef LDST_ALIGN_CHECK_EN
        ,
        .cdb_exc        (cdb_exc)
`endif
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected access plan for one operation.
    int          p_n;
    bit          p_rd[2];
    logic [15:0] p_addr[2];
    logic [15:0] p_wd[2];
    logic [1:0]  p_be[2];
    logic [15:0] p_rdat[2];
    logic [15:0] p_val;
    bit          p_exc;

    task automatic plan(lc3b_opcode op, logic [15:0] base,
                        logic [15:0] off, logic [15:0] src,
                        logic [15:0] r0, logic [15:0] r1);
        bit          word;
        logic [15:0] e;
        logic [7:0]  b;
        word = (op == op_ldr) || (op == op_str) ||
               (op == op_ldi) || (op == op_sti);
        e = word ? base + off + off : base + off;
        p_rdat[0] = r0;
        p_rdat[1] = r1;
        p_exc = 0;
        p_val = 16'h0;
        p_n = 0;
`ifdef LDST_ALIGN_CHECK_EN
        if (word && e[0]) begin
            p_exc = 1;
            return;
        end
`endif
        p_n = 1;
        p_rd[0] = !(op == op_str || op == op_stb);
        p_addr[0] = e & 16'hFFFE;
        p_wd[0] = src;
        p_be[0] = 2'b11;
        if (op == op_stb) begin
            p_wd[0] = {src[7:0], src[7:0]};
            p_be[0] = e[0] ? 2'b10 : 2'b01;
        end
        if (op == op_ldr)
            p_val = r0;
        if (op == op_ldb) begin
            b = e[0] ? r0[15:8] : r0[7:0];
            p_val = (b >= 8'd128) ? 16'hFF00 + b : {8'h0, b};
        end
        if (op == op_ldi || op == op_sti) begin
`ifdef LDST_ALIGN_CHECK_EN
            if (r0[0]) begin
                p_exc = 1;
                return;
            end
`endif
            p_n = 2;
            p_rd[1] = (op == op_ldi);
            p_addr[1] = r0 & 16'hFFFE;
            p_wd[1] = src;
            p_be[1] = 2'b11;
            if (op == op_ldi)
                p_val = r1;
        end
    endtask

    // Drives one op from an idle negedge to the negedge after ack.
    task automatic run_op(string nm, lc3b_opcode op,
                          logic [15:0] base, logic [15:0] off,
                          logic [15:0] src, logic [2:0] dest,
                          logic [15:0] r0, logic [15:0] r1,
                          int rd_dly, int ack_dly);
        plan(op, base, off, src, r0, r1);
        chk({nm, ":idle_ready"}, req_ready, 1);
        req_valid = 1'b1;
        opcode_in = op;
        Vbase_in = base;
        offset_in = off;
        Vsrc_in = src;
        dest_in = dest;
        @(negedge clk);
        req_valid = 1'b0;
        Vbase_in = 16'($urandom);
        offset_in = 16'($urandom);
        Vsrc_in = 16'($urandom);
        dest_in = 3'($urandom);
        chk({nm, ":addr_ready"}, req_ready, 0);
        chk({nm, ":addr_strobe"}, {mem_read, mem_write}, 0);
        @(negedge clk);
        for (int i = 0; i < p_n; i++) begin
            if (i == 1) begin
                chk({nm, ":indir_strobe"}, {mem_read, mem_write}, 0);
                @(negedge clk);
            end
            for (int k = 0; k <= rd_dly; k++) begin
                chk({nm, ":rd"}, mem_read, p_rd[i]);
                chk({nm, ":wr"}, mem_write, !p_rd[i]);
                chk({nm, ":address"}, mem_address, p_addr[i]);
                chk({nm, ":mem_ready"}, req_ready, 0);
                if (!p_rd[i]) begin
                    chk({nm, ":wdata"}, mem_wdata, p_wd[i]);
                    chk({nm, ":be"}, mem_byte_enable, p_be[i]);
                end
                if (k == rd_dly) begin
                    mem_resp = 1'b1;
                    mem_rdata = p_rdat[i];
                end
                @(negedge clk);
            end
            mem_resp = 1'b0;
            mem_rdata = 16'($urandom);
        end
        if ((op == op_ldi || op == op_sti) && p_n == 1) begin
            chk({nm, ":indir_strobe"}, {mem_read, mem_write}, 0);
            @(negedge clk);
        end
        for (int k = 0; k <= ack_dly; k++) begin
            chk({nm, ":cdb_valid"}, cdb_valid, 1);
            chk({nm, ":cdb_tag"}, cdb_tag, dest);
            chk({nm, ":cdb_value"}, cdb_value, p_val);
            chk({nm, ":bcast_ready"}, req_ready, 0);
            chk({nm, ":bcast_strobe"}, {mem_read, mem_write}, 0);
`ifdef LDST_ALIGN_CHECK_EN
            chk({nm, ":cdb_exc"}, cdb_exc, p_exc);
`endif
            if (k == ack_dly)
                cdb_ack = 1'b1;
            @(negedge clk);
        end
        cdb_ack = 1'b0;
        chk({nm, ":post_valid"}, cdb_valid, 0);
        chk({nm, ":post_ready"}, req_ready, 1);
    endtask

    lc3b_opcode ops[6] = '{op_ldr, op_str, op_ldb,
                           op_stb, op_ldi, op_sti};

    initial begin
        logic [5:0]  o6;
        logic [15:0] off;
        // Reset state.
        repeat (2) @(negedge clk);
        flush = 1'b0;
        chk("rst:ready", req_ready, 1);
        chk("rst:strobe", {mem_read, mem_write}, 0);
        chk("rst:cdb_valid", cdb_valid, 0);
        chk("rst:address", mem_address, 0);
        chk("rst:wdata", mem_wdata, 0);
        chk("rst:be", mem_byte_enable, 0);
        chk("rst:tag", cdb_tag, 0);
        chk("rst:value", cdb_value, 0);

        // Directed cases.
        run_op("ldr", op_ldr, 16'h1000, 16'd3, 16'h0, 3'd5,
               16'hBEEF, 16'h0, 2, 0);
        run_op("ldb_hi", op_ldb, 16'h2001, 16'd0, 16'h0, 3'd1,
               16'h80FF, 16'h0, 0, 0);
        run_op("ldb_lo", op_ldb, 16'h2000, 16'd0, 16'h0, 3'd2,
               16'h80FF, 16'h0, 1, 0);
        run_op("stb", op_stb, 16'h3000, 16'd1, 16'h12AB, 3'd3,
               16'h0, 16'h0, 0, 0);
        run_op("sti", op_sti, 16'h4000, 16'hFFFF, 16'h7777, 3'd4,
               16'h5000, 16'h0, 1, 0);
        run_op("ldi", op_ldi, 16'h0100, 16'd2, 16'h0, 3'd6,
               16'h0A00, 16'h4321, 0, 1);
        run_op("ack_hold", op_str, 16'h0200, 16'd1, 16'hCAFE, 3'd7,
               16'h0, 16'h0, 0, 4);
        run_op("wrap", op_ldr, 16'hFFFE, 16'd2, 16'h0, 3'd0,
               16'h1357, 16'h0, 0, 0);

        // Flush while MEM1 waits for a response.
        req_valid = 1'b1;
        opcode_in = op_ldr;
        Vbase_in = 16'h0500;
        offset_in = 16'd0;
        dest_in = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush:pre_rd", mem_read, 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush:ready", req_ready, 1);
        chk("flush:strobe", {mem_read, mem_write}, 0);
        chk("flush:cdb", cdb_valid, 0);
        mem_resp = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk);
        chk("stray:ready", req_ready, 1);
        chk("stray:cdb", cdb_valid, 0);
        chk("stray:strobe", {mem_read, mem_write}, 0);
        run_op("after_flush", op_ldb, 16'h0600, 16'd1, 16'h0, 3'd2,
               16'h7F00, 16'h0, 0, 0);

        // Random operations.
        for (int n = 0; n < 150; n++) begin
            o6 = 6'($urandom);
            off = {{10{o6[5]}}, o6};
            run_op("rand", ops[$urandom_range(0, 5)],
                   16'($urandom), off, 16'($urandom),
                   3'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
